// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int DEFAULT_CLK_HZ     = 25000000;
  localparam int DEFAULT_TIMEOUT_US = 2000;

  function automatic int timeout_cyc(input int clk_hz, input int timeout_us);
    return (clk_hz / 1000000) * timeout_us;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DEFAULT_TIMEOUT_CYC = timeout_cyc(DEFAULT_CLK_HZ, DEFAULT_TIMEOUT_US);

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// First-word-fall-through FIFO; head word held in a register fed from the
// storage array at the next read address (write data bypassed when needed).
module ps2_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             data,
  output logic [ptr_width(DEPTH):0]    count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             push_eff, pop_eff;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (PTR_W+1)'(DEPTH));
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);

  always_comb begin
    rd_ptr_next = rd_ptr_reg + PTR_W'(pop_eff);
    count_next  = count_reg;
    if (push_eff && !pop_eff)
      count_next = count_reg + 1'b1;
    else if (pop_eff && !push_eff)
      count_next = count_reg - 1'b1;
    data_next = data_reg;
    // The new head is either the word being written this cycle or one already stored.
    if ((push_eff || pop_eff) && count_next != '0)
      data_next = (push_eff && rd_ptr_next == wr_ptr_reg) ? din : mem[rd_ptr_next];
  end

  always_ff @(posedge clock) begin
    if (push_eff)
      mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      data_reg   <= '0;
    end else begin
      if (push_eff)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      data_reg   <= data_next;
    end
  end

  assign data  = data_reg;
  assign count = count_reg;

endmodule

// File: rtl/ps2_kbd_rx.sv
// Receive-only PS/2 keyboard port: synchronise, glitch-filter the clock,
// deserialise 11-bit frames and queue good scancodes in a small FIFO.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int TIMEOUT_US = 2000,
  parameter int FILTER_LEN = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_dat,
  input  logic                          rd,
  input  logic                          ovf_clr,
  output logic [7:0]                    data,
  output logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          err,
  output logic                          overflow
);

  localparam int TIMEOUT_CYC = timeout_cyc(CLK_HZ, TIMEOUT_US);
  localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]            clk_sync_reg, dat_sync_reg;
  logic [FILTER_LEN-1:0] filt_reg;
  logic                  filt_clk_reg, filt_clk_d_reg;
  logic                  fall, dat_s;

  ps2_state_t            state_reg, state_next;
  logic [2:0]            bit_idx_reg, bit_idx_next;
  logic [7:0]            shift_reg, shift_next;
  logic                  par_reg, par_next;
  logic [TO_W-1:0]       to_cnt_reg, to_cnt_next;
  logic                  err_reg, err_next;
  logic                  overflow_reg;
  logic                  push, drop, fifo_full, fifo_empty;

  assign dat_s = dat_sync_reg[1];
  assign fall  = filt_clk_d_reg && !filt_clk_reg;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      clk_sync_reg   <= 2'b11;
      dat_sync_reg   <= 2'b11;
      filt_reg       <= '1;
      filt_clk_reg   <= 1'b1;
      filt_clk_d_reg <= 1'b1;
    end else begin
      clk_sync_reg   <= {clk_sync_reg[0], ps2_clk};
      dat_sync_reg   <= {dat_sync_reg[0], ps2_dat};
      filt_reg       <= {filt_reg[FILTER_LEN-2:0], clk_sync_reg[1]};
      filt_clk_d_reg <= filt_clk_reg;
      // Hysteresis: only a full run of equal samples moves the filtered clock.
      if (filt_reg == '0)
        filt_clk_reg <= 1'b0;
      else if (filt_reg == '1)
        filt_clk_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    par_next     = par_reg;
    push         = 1'b0;
    err_next     = 1'b0;
    to_cnt_next  = (fall || state_reg == IDLE) ? '0 : to_cnt_reg + 1'b1;
    if (fall) begin
      case (state_reg)
        IDLE: begin
          if (!dat_s) begin
            state_next   = DATA;
            bit_idx_next = 3'd0;
          end
        end
        DATA: begin
          shift_next   = {dat_s, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7)
            state_next = PARITY;
        end
        PARITY: begin
          par_next   = dat_s;
          state_next = STOP;
        end
        STOP: begin
          if (dat_s && odd_parity_ok(shift_reg, par_reg))
            push = 1'b1;
          else
            err_next = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (state_reg != IDLE && to_cnt_reg == TO_W'(TIMEOUT_CYC - 1)) begin
      state_next = IDLE;
      err_next   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'd0;
      par_reg     <= 1'b0;
      to_cnt_reg  <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      par_reg     <= par_next;
      to_cnt_reg  <= to_cnt_next;
      err_reg     <= err_next;
    end
  end

  // A drop only happens when the FIFO is full and not being drained this cycle.
  assign drop = push && fifo_full && !(rd && ready);

  always_ff @(posedge clock) begin
    if (!reset_n)
      overflow_reg <= 1'b0;
    else if (drop)
      overflow_reg <= 1'b1;
    else if (ovf_clr)
      overflow_reg <= 1'b0;
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (rd),
    .din     (shift_reg),
    .data    (data),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign ready    = !fifo_empty;
  assign err      = err_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: bit-banged PS/2 frames, scoreboard queue of expected bytes.
module tb_ps2_kbd_rx;

  localparam int HALF = 50;  // PS/2 half-period in system clocks

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rd = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] data;
  logic       ready;
  logic [3:0] count;
  logic       err;
  logic       overflow;

  ps2_kbd_rx dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .rd       (rd),
    .ovf_clr  (ovf_clr),
    .data     (data),
    .ready    (ready),
    .count    (count),
    .err      (err),
    .overflow (overflow)
  );

  always #20 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int err_pulses = 0;
  int err_rise_cyc = 0;
  int ready_rise_cyc = 0;
  int err_run = 0;
  int err_max_run = 0;
  logic err_prev = 1'b0;
  logic ready_prev = 1'b0;

  logic [7:0] exp_q[$];
  logic       m_ovf = 1'b0;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    int         exp_err;
    int         exp_cnt;
    int         reads;
  } vec_t;

  vec_t vecs[6];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (err) begin
      if (!err_prev) begin
        err_pulses++;
        err_rise_cyc = cyc;
        err_run = 1;
      end else begin
        err_run++;
      end
      if (err_run > err_max_run) err_max_run = err_run;
    end
    if (ready && !ready_prev) ready_rise_cyc = cyc;
    err_prev = err;
    ready_prev = ready;
  end

  initial begin
    repeat (98000) @(posedge clock);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    tick(HALF);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    ps2_bit(s);
    ps2_dat = 1'b1;
    tick(HALF);
    if (s && (^{d, p})) begin
      if (exp_q.size() < 8) exp_q.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, int'(count), exp_q.size());
    chk({tag, "_ready"}, int'(ready), (exp_q.size() != 0) ? 1 : 0);
    chk({tag, "_ovf"}, int'(overflow), int'(m_ovf));
    if (exp_q.size() != 0) chk({tag, "_data"}, int'(data), int'(exp_q[0]));
  endtask

  task automatic do_rd();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  initial begin
    int e0;
    int lat;
    int n;
    logic [7:0] b;

    vecs[0] = '{d: 8'h1C, p: 1'b0, s: 1'b1, exp_err: 0, exp_cnt: 1, reads: 1};
    vecs[1] = '{d: 8'hF0, p: 1'b1, s: 1'b1, exp_err: 0, exp_cnt: 1, reads: 0};
    vecs[2] = '{d: 8'h1C, p: 1'b0, s: 1'b1, exp_err: 0, exp_cnt: 2, reads: 0};
    vecs[3] = '{d: 8'h1C, p: 1'b1, s: 1'b1, exp_err: 1, exp_cnt: 0, reads: 0};
    vecs[4] = '{d: 8'h33, p: 1'b1, s: 1'b0, exp_err: 1, exp_cnt: 0, reads: 0};
    vecs[5] = '{d: 8'hA5, p: 1'b1, s: 1'b1, exp_err: 0, exp_cnt: 1, reads: 1};

    tick(4);
    chk("rst_data", int'(data), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ovf", int'(overflow), 0);
    reset_n = 1'b1;
    tick(20);

    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        // Hand sequence: drain the two queued bytes, then a read on empty.
        chk("seq_head", int'(data), 8'hF0);
        do_rd();
        chk("seq_rd1_data", int'(data), 8'h1C);
        check_state("seq_rd1");
        do_rd();
        check_state("seq_rd2");
        do_rd();
        tick(2);
        check_state("seq_rd_empty");
      end
      e0 = err_pulses;
      send_frame(vecs[i].d, vecs[i].p, vecs[i].s);
      chk($sformatf("vec%0d_err", i), err_pulses - e0, vecs[i].exp_err);
      chk($sformatf("vec%0d_cnt_tbl", i), int'(count), vecs[i].exp_cnt);
      check_state($sformatf("vec%0d", i));
      if (i == 0) begin
        lat = ready_rise_cyc - last_fall_cyc;
        chk("ready_latency_window", (lat >= 10 && lat <= 14) ? 1 : 0, 1);
      end
      for (int r = 0; r < vecs[i].reads; r++) do_rd();
      tick(2);
    end
    chk("err_pulse_width", err_max_run, 1);

    // Timeout: start bit plus four data bits, then the clock stops.
    e0 = err_pulses;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0]);
    ps2_dat = 1'b1;
    n = 0;
    while (err_pulses == e0 && n < 60000) begin
      tick(1);
      n++;
    end
    chk("timeout_err", err_pulses - e0, 1);
    lat = err_rise_cyc - last_fall_cyc;
    chk("timeout_delay_window", (lat >= 50000 && lat <= 50020) ? 1 : 0, 1);
    chk("timeout_cnt", int'(count), 0);
    e0 = err_pulses;
    send_frame(8'h5A, 1'b1, 1'b1);
    chk("after_to_err", err_pulses - e0, 0);
    chk("after_to_data", int'(data), 8'h5A);
    check_state("after_to");
    do_rd();
    tick(2);

    // Short low glitch on the clock while idle must be ignored.
    e0 = err_pulses;
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(30);
    chk("glitch_err", err_pulses - e0, 0);
    check_state("glitch");

    // Nine frames into an eight-entry FIFO.
    for (int k = 1; k <= 9; k++) begin
      b = k[7:0];
      send_frame(b, ~^b, 1'b1);
    end
    chk("ovf_count", int'(count), 8);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_head", int'(data), 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    m_ovf = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain%0d", k), int'(data), k);
      do_rd();
    end
    tick(1);
    check_state("drained");

    // Reset in the middle of a frame.
    send_frame(8'h77, 1'b1, 1'b1);
    check_state("pre_rst");
    e0 = err_pulses;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    exp_q.delete();
    m_ovf = 1'b0;
    tick(2);
    chk("midrst_count", int'(count), 0);
    chk("midrst_ready", int'(ready), 0);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("postrst_data", int'(data), 8'h1C);
    chk("postrst_err", err_pulses - e0, 0);
    check_state("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
